uart_tx_port: RTL and testbench

Serial transmit back end for the core's memory-less UART path. It watches the 8-bit byte the register file exposes from x12 and detects a software "send" on each zero-to-nonzero transition. It queues that byte in a small FIFO and shifts it out as 8N1 on a single `tx` line. It also returns a `busy` status that the top level ORs into the GPIO input byte, so software can poll for completion through x11.

---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/uart_tx_port.sv | 142 ++++++++++++++
 tb/tb_uart_tx_port.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int UART_DATA_W          = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 868;   // 100 MHz / 115200 baud

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; a push while full is accepted
// only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en;
    logic             rd_en;

    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        rdata = mem_q[rd_ptr_q[AW-1:0]];
        wr_en = push && (!full || pop);
        rd_en = pop && !empty;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    // NOTE: reset is sampled on the clock edge only; it is part of the data path.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_tx_port.sv
// 8N1 transmitter fed by zero-to-nonzero transitions of the x12 byte,
// with a small byte queue, busy status and sticky overflow.
module uart_tx_port
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [UART_DATA_W-1:0] data_in,
    output logic                   tx,
    output logic                   busy,
    output logic                   overflow
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_START = START;
    localparam logic [1:0] ST_DATA  = DATA;
    localparam logic [1:0] ST_STOP  = STOP;

    logic                   armed_q, armed_d;
    logic                   push_q, push_d;
    logic [UART_DATA_W-1:0] push_data_q, push_data_d;
    logic                   overflow_q, overflow_d;
    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;

    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [UART_DATA_W-1:0] fifo_rdata;
    logic                   baud_done;

    sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_q),
        .pop   (fifo_pop),
        .wdata (push_data_q),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // One push per nonzero episode; a zero byte re-arms.
    // NOTE: combinational blocks use blocking '=' with defaults first; flops use '<='.
    always_comb begin
        armed_d     = armed_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        if (data_in == '0) begin
            armed_d = 1'b1;
        end else if (armed_q) begin
            armed_d     = 1'b0;
            push_d      = 1'b1;
            push_data_d = data_in;
        end
        overflow_d = overflow_q || (push_q && fifo_full && !fifo_pop);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
        baud_done = (cnt_q == CNT_LAST);

        if (state_q != ST_IDLE) cnt_d = baud_done ? '0 : cnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) state_d = ST_STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            ST_STOP: begin
                if (baud_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            armed_q     <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            overflow_q  <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
        end else begin
            armed_q     <= armed_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            overflow_q  <= overflow_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
        end
    end

    // Outputs decode only registered state, so nothing reaches them from data_in.
    always_comb begin
        case (state_q)
            ST_START: tx = 1'b0;
            ST_DATA:  tx = shift_q[0];
            default:  tx = 1'b1;
        endcase
        busy     = (state_q != ST_IDLE) || !fifo_empty;
        overflow = overflow_q;
    end

endmodule

// File: tb/tb_uart_tx_port.sv
// Self-checking bench: a schedule-level model predicts tx, busy and overflow
// every cycle from the send rules, frame timing and queue capacity.
module tb_uart_tx_port;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in;
    logic       tx;
    logic       busy;
    logic       overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: per accepted byte, its FIFO write cycle, start-bit cycle and value.
    bit         armed_m;
    int         ovf_from;
    int         last_s;
    int         w_q[$];
    int         s_q[$];
    logic [7:0] b_q[$];

    uart_tx_port #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .tx       (tx),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        armed_m  = 1'b0;
        ovf_from = 32'h3fff_ffff;
        last_s   = -1000;
        w_q.delete();
        s_q.delete();
        b_q.delete();
    endfunction

    function automatic void model_arm(input logic [7:0] d);
        int w;
        int occ;
        int s;
        if (d == 8'h00) begin
            armed_m = 1'b1;
        end else if (armed_m) begin
            armed_m = 1'b0;
            w   = cyc + 1;
            occ = 0;
            foreach (w_q[i])
                if (w_q[i] < w && s_q[i] - 1 > w) occ++;
            if (occ < DEPTH) begin
                s = (w + 2 > last_s + FRAME + 1) ? w + 2 : last_s + FRAME + 1;
                last_s = s;
                w_q.push_back(w);
                s_q.push_back(s);
                b_q.push_back(d);
            end else if (ovf_from > w + 1) begin
                ovf_from = w + 1;
            end
        end
    endfunction

    function automatic logic exp_tx(input int c);
        int k;
        foreach (s_q[i]) begin
            if (c >= s_q[i] && c < s_q[i] + FRAME) begin
                k = (c - s_q[i]) / CPB;
                if (k == 0) return 1'b0;
                if (k == 9) return 1'b1;
                return b_q[i][k-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic exp_busy(input int c);
        foreach (s_q[i])
            if (w_q[i] < c && c <= s_q[i] + FRAME - 1) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, exp);
        end
    endtask

    // One clock period: drive, sample mid-cycle, advance.
    task automatic step(input logic [7:0] d, input logic r);
        data_in = d;
        rst_n   = r;
        if (r) model_arm(d);
        @(negedge clk);
        check("tx", tx, exp_tx(cyc));
        check("busy", busy, exp_busy(cyc));
        check("overflow", overflow, logic'(cyc >= ovf_from));
        if (!r) model_clear();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(8'h00, 1'b1);
    endtask

    task automatic send(input logic [7:0] b);
        step(b, 1'b1);
        step(8'h00, 1'b1);
    endtask

    function automatic logic [7:0] rand_byte();
        return 8'($urandom_range(1, 255));
    endfunction

    initial begin
        int target;
        logic [7:0] b;

        // Reset hold with a nonzero byte present.
        rst_n   = 1'b0;
        data_in = 8'h55;
        model_clear();
        @(posedge clk);
        #1;
        step(8'h55, 1'b0);
        step(8'h55, 1'b0);
        repeat (20) step(8'h55, 1'b1);
        idle(3);

        // Single byte.
        send(8'h41);
        idle(50);

        // Held byte sends once.
        repeat (200) step(8'h41, 1'b1);
        idle(50);

        // Back-to-back queued bytes.
        send(8'h31);
        send(8'h32);
        send(8'h33);
        idle(130);

        // Overflow: six sends in twelve cycles.
        repeat (6) send(rand_byte());
        idle(220);

        // Reset clears overflow; then push arriving on the pop cycle of a full queue.
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
        idle(3);
        repeat (5) send(rand_byte());
        target = s_q[0] + FRAME - 1;
        while (cyc < target) idle(1);
        send(rand_byte());
        idle(260);

        // Random bursts.
        repeat (60) begin
            idle(int'($urandom_range(1, 3)));
            b = rand_byte();
            repeat ($urandom_range(1, 3)) step(b, 1'b1);
        end
        idle(260);

        // Reset during data bit 3 of a frame.
        send(8'hA5);
        target = s_q[s_q.size() - 1] + 4 * CPB + 1;
        while (cyc < target) idle(1);
        step(8'h00, 1'b0);
        idle(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
